// File: rtl/key_cmd_pkg.sv
// Shared encodings, FSM state type and default timing constants for the
// key press decoder and its debouncer.
package key_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_STOP  = 2'b00,
    CMD_LEFT  = 2'b01,
    CMD_RIGHT = 2'b10
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_HELD   = 2'b01,
    ST_REPORT = 2'b10
  } state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_TICK_CYCLES     = 50_000_000;
  localparam int DEF_LEFT_MIN        = 1;
  localparam int DEF_RIGHT_MIN       = 4;

  localparam logic [3:0] HOLD_MAX = 4'd15;

  // Maps whole held seconds onto a command.
  function automatic cmd_e classify_hold(input logic [3:0] hold,
                                         input int left_min,
                                         input int right_min);
    cmd_e c;
    if (int'(hold) >= right_min) begin
      c = CMD_RIGHT;
    end else if (int'(hold) >= left_min) begin
      c = CMD_LEFT;
    end else begin
      c = CMD_STOP;
    end
    return c;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus counter debouncer for an active-low push button;
// o_pressed is the accepted level, 1 = held.
module key_debounce
  import key_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_pressed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_pressed;
  logic          w_differs;

  // Sync flops reset to the released level so a held key reads as a new press.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Raw level is active-low, so a sample equal to r_pressed disagrees with it.
  assign w_differs = (r_sync2 == r_pressed);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_pressed <= 1'b0;
    end else if (!w_differs) begin
      r_cnt     <= '0;
      r_pressed <= r_pressed;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt     <= '0;
      r_pressed <= ~r_sync2;
    end else begin
      r_cnt     <= r_cnt + CW'(1);
      r_pressed <= r_pressed;
    end
  end

  assign o_pressed = r_pressed;

endmodule

// File: rtl/key_press_decoder.sv
// Debounced push-button hold timer: measures whole seconds held and reports
// STOP/LEFT/RIGHT with a one-cycle cmd_valid pulse after each release.
module key_press_decoder
  import key_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TICK_CYCLES     = DEF_TICK_CYCLES,
  parameter int LEFT_MIN        = DEF_LEFT_MIN,
  parameter int RIGHT_MIN       = DEF_RIGHT_MIN
) (
  input  logic       CLOCK_50Mhz,
  input  logic       RST,
  input  logic       KEY,
  output logic       pressed,
  output logic [3:0] hold_sec,
  output logic [1:0] cmd,
  output logic       cmd_valid
);

  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  logic          w_pressed;
  state_e        r_state;
  state_e        w_state_nxt;
  logic [TW-1:0] r_tick;
  logic [TW-1:0] w_tick_nxt;
  logic [3:0]    r_hold;
  logic [3:0]    w_hold_nxt;
  cmd_e          r_cmd;
  cmd_e          w_cmd_nxt;
  logic          r_cmd_valid;
  logic          w_cmd_valid_nxt;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .i_clk    (CLOCK_50Mhz),
    .i_rst    (RST),
    .i_key_n  (KEY),
    .o_pressed(w_pressed)
  );

  // IDLE is only ever occupied with pressed low, so its level acts as the rising edge.
  always_comb begin
    w_state_nxt     = r_state;
    w_tick_nxt      = r_tick;
    w_hold_nxt      = r_hold;
    w_cmd_nxt       = r_cmd;
    w_cmd_valid_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pressed) begin
          w_state_nxt = ST_HELD;
          w_tick_nxt  = '0;
          w_hold_nxt  = 4'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (w_pressed) begin
          if (r_tick == TICK_LAST) begin
            w_tick_nxt = '0;
            if (r_hold != HOLD_MAX) begin
              w_hold_nxt = r_hold + 4'd1;
            end else begin
              w_hold_nxt = r_hold;
            end
          end else begin
            w_tick_nxt = r_tick + TW'(1);
          end
        end else begin
          // Release: partial tick is dropped, hold_sec stays frozen.
          w_state_nxt     = ST_REPORT;
          w_cmd_nxt       = classify_hold(r_hold, LEFT_MIN, RIGHT_MIN);
          w_cmd_valid_nxt = 1'b1;
        end
      end
      ST_REPORT: begin
        if (w_pressed) begin
          w_state_nxt = ST_HELD;
          w_tick_nxt  = '0;
          w_hold_nxt  = 4'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLOCK_50Mhz or posedge RST) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_tick      <= '0;
      r_hold      <= 4'd0;
      r_cmd       <= CMD_STOP;
      r_cmd_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tick      <= w_tick_nxt;
      r_hold      <= w_hold_nxt;
      r_cmd       <= w_cmd_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
    end
  end

  assign pressed   = w_pressed;
  assign hold_sec  = r_hold;
  assign cmd       = r_cmd;
  assign cmd_valid = r_cmd_valid;

endmodule
